// File: rtl/shift_sequencer_if.sv
// Request/grant/result bundle between the two requesters and the shift engine.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             Req0;
  logic [1:0]       Op0;
  logic [WIDTH-1:0] A0;
  logic [SHW-1:0]   Shamt0;
  logic             Req1;
  logic [1:0]       Op1;
  logic [WIDTH-1:0] A1;
  logic [SHW-1:0]   Shamt1;
  logic             Grant0;
  logic             Grant1;
  logic             Busy;
  logic             Done;
  logic             DoneId;
  logic [WIDTH-1:0] Result;

  // Requester side (ALU issue / address-IO unit, or a testbench).
  modport master (
    output Req0, Op0, A0, Shamt0, Req1, Op1, A1, Shamt1,
    input  Grant0, Grant1, Busy, Done, DoneId, Result
  );

  // Engine side.
  modport slave (
    input  Req0, Op0, A0, Shamt0, Req1, Op1, A1, Shamt1,
    output Grant0, Grant1, Busy, Done, DoneId, Result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Bit-serial shift engine shared by two requesters. Round-robin arbitration
// in IDLE, one shift per clock in SHIFT, one-cycle Done pulse in DONE.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic              Clock,
  input  logic              ResetN,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_id_q, done_id_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             grant0, grant1;
  logic             sel;
  logic [WIDTH-1:0] shifted;

  // One-bit shift of the working operand according to the latched op.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w, input op_e op);
    case (op)
      OP_SLL:  shift_one = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  shift_one = {w[WIDTH-1], w[WIDTH-1:1]};
      default: shift_one = {w[0], w[WIDTH-1:1]};
    endcase
  endfunction

  // Arbitration: only in IDLE; on a tie the port that was not served last wins.
  always_comb begin
    grant0 = (state_q == S_IDLE) && bus.Req0 && (!bus.Req1 || last_id_q);
    grant1 = (state_q == S_IDLE) && bus.Req1 && (!bus.Req0 || !last_id_q);
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    sel       = grant1;
    shifted   = shift_one(work_q, op_q);

    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          work_d    = sel ? bus.A1 : bus.A0;
          op_d      = op_e'(sel ? bus.Op1 : bus.Op0);
          cnt_d     = sel ? bus.Shamt1 : bus.Shamt0;
          id_d      = sel;
          last_id_d = sel;
          if ((sel ? bus.Shamt1 : bus.Shamt0) == '0) begin
            // Zero shift goes straight to DONE with the untouched operand.
            state_d   = S_DONE;
            result_d  = sel ? bus.A1 : bus.A0;
            done_id_d = sel;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d   = S_DONE;
          result_d  = shifted;
          done_id_d = id_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset discards any in-flight op.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SLL;
      work_q    <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      result_q  <= '0;
      done_id_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Grant0 = grant0;
  assign bus.Grant1 = grant1;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.DoneId = done_id_q;
  assign bus.Result = result_q;

endmodule
